// File: rtl/audio_vis_pkg.sv
// -----------------------------------------------------------------------------
// audio_vis_pkg
// Shared definitions for the framebuffer pixel writer:
//   - fbw_state_e       : writer FSM state encoding
//   - FB_ADDRESS_LENGTH : default framebuffer word-address width
//   - FB_DATA_WIDTH     : default framebuffer word width (1 bit per pixel)
// -----------------------------------------------------------------------------
package audio_vis_pkg;

    localparam int FB_ADDRESS_LENGTH = 14;
    localparam int FB_DATA_WIDTH     = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_MODIFY = 2'd2,
        ST_CLEAR  = 2'd3
    } fbw_state_e;

endpackage

// File: rtl/fb_clear_sequencer.sv
// -----------------------------------------------------------------------------
// fb_clear_sequencer
// Address counter for a framebuffer clear sweep. A start strobe begins a sweep
// at address 0; the address then advances one word per cycle up to
// NUM_WORDS-1, after which the sequencer goes idle without wrapping.
// Ports:
//   clk    - clock
//   resetn - asynchronous active-low reset
//   start  - one-cycle strobe beginning a sweep
//   busy   - a sweep is in progress (addr is valid)
//   addr   - current word address of the sweep
//   done   - current addr is the last word of the sweep
// -----------------------------------------------------------------------------
module fb_clear_sequencer
    import audio_vis_pkg::*;
#(
    parameter int ADDRESS_LENGTH = FB_ADDRESS_LENGTH,
    parameter int NUM_WORDS      = 2 ** ADDRESS_LENGTH
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    output logic                      busy,
    output logic [ADDRESS_LENGTH-1:0] addr,
    output logic                      done
);

    localparam logic [ADDRESS_LENGTH-1:0] LAST_ADDR = ADDRESS_LENGTH'(NUM_WORDS - 1);

    logic                      busy_q, busy_d;
    logic [ADDRESS_LENGTH-1:0] addr_q, addr_d;

    always_comb begin
        busy_d = busy_q;
        addr_d = addr_q;
        if (start) begin
            busy_d = 1'b1;
            addr_d = '0;
        end else if (busy_q) begin
            if (addr_q == LAST_ADDR) begin
                // Park at 0 rather than wrapping into a second sweep.
                busy_d = 1'b0;
                addr_d = '0;
            end else begin
                addr_d = addr_q + ADDRESS_LENGTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q <= 1'b0;
            addr_q <= '0;
        end else begin
            busy_q <= busy_d;
            addr_q <= addr_d;
        end
    end

    assign busy = busy_q;
    assign addr = addr_q;
    assign done = busy_q && (addr_q == LAST_ADDR);

endmodule

// File: rtl/framebuffer_pixel_writer.sv
// -----------------------------------------------------------------------------
// framebuffer_pixel_writer
// Sets single pixels in a 1-bit-per-pixel framebuffer held in a BRAM with a
// one-cycle read latency, using a 3-cycle read-modify-write, and can sweep the
// whole framebuffer to zero on request.
// Ports:
//   clk, resetn             - clock, asynchronous active-low reset
//   word_address, bit_offset- pixel location (word + bit within word)
//   word_and_offset_valid   - request strobe, accepted only while in_ready=1
//   in_ready                - writer is idle and can take a request
//   clear_req               - request a full clear (wins over a same-cycle pixel)
//   clear_busy              - clear sweep in progress
//   bram_en/we/addr/din     - BRAM port drive
//   bram_dout               - BRAM read data, valid the cycle after a read
//   dropped                 - sticky: a pixel request was lost
//   pixel_count             - completed pixel writes (only with
//                             FRAMEBUFFER_PIXEL_WRITER_STATS_EN defined)
// Optional feature macro: FRAMEBUFFER_PIXEL_WRITER_STATS_EN
// -----------------------------------------------------------------------------
module framebuffer_pixel_writer
    import audio_vis_pkg::*;
#(
    parameter int ADDRESS_LENGTH = FB_ADDRESS_LENGTH,
    parameter int DATA_WIDTH     = FB_DATA_WIDTH,
    parameter int NUM_WORDS      = 2 ** ADDRESS_LENGTH
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [ADDRESS_LENGTH-1:0] word_address,
    input  logic [4:0]                bit_offset,
    input  logic                      word_and_offset_valid,
    output logic                      in_ready,
    input  logic                      clear_req,
    output logic                      clear_busy,
    output logic                      bram_en,
    output logic                      bram_we,
    output logic [ADDRESS_LENGTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0]     bram_din,
    input  logic [DATA_WIDTH-1:0]     bram_dout,
    output logic                      dropped
`ifdef FRAMEBUFFER_PIXEL_WRITER_STATS_EN
    ,
    output logic [31:0]               pixel_count
`endif
);

    fbw_state_e                state_q;
    logic                      in_ready_q;
    logic                      bram_en_q, bram_we_q;
    logic [ADDRESS_LENGTH-1:0] addr_q;
    logic [4:0]                off_q;
    logic                      pending_clear_q;
    logic                      dropped_q;

    logic                      clear_start;
    logic                      seq_busy, seq_done;
    logic [ADDRESS_LENGTH-1:0] seq_addr;
    logic [DATA_WIDTH-1:0]     pixel_mask;

    // A clear begins from IDLE directly, or straight after MODIFY when one was
    // requested during the RMW (latched or arriving in MODIFY itself).
    assign clear_start = ((state_q == ST_IDLE) && clear_req) ||
                         ((state_q == ST_MODIFY) && (pending_clear_q || clear_req));

    fb_clear_sequencer #(
        .ADDRESS_LENGTH (ADDRESS_LENGTH),
        .NUM_WORDS      (NUM_WORDS)
    ) u_clear_seq (
        .clk    (clk),
        .resetn (resetn),
        .start  (clear_start),
        .busy   (seq_busy),
        .addr   (seq_addr),
        .done   (seq_done)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= ST_IDLE;
            in_ready_q      <= 1'b1;
            bram_en_q       <= 1'b0;
            bram_we_q       <= 1'b0;
            addr_q          <= '0;
            off_q           <= '0;
            pending_clear_q <= 1'b0;
            dropped_q       <= 1'b0;
        end else begin
            // A clear in the same IDLE cycle also costs the pixel.
            if (word_and_offset_valid && (!in_ready_q || clear_req)) begin
                dropped_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (clear_req) begin
                        state_q    <= ST_CLEAR;
                        in_ready_q <= 1'b0;
                        bram_en_q  <= 1'b1;
                        bram_we_q  <= 1'b1;
                    end else if (word_and_offset_valid) begin
                        state_q    <= ST_READ;
                        in_ready_q <= 1'b0;
                        bram_en_q  <= 1'b1;
                        bram_we_q  <= 1'b0;
                        addr_q     <= word_address;
                        off_q      <= bit_offset;
                    end
                end
                ST_READ: begin
                    if (clear_req) begin
                        pending_clear_q <= 1'b1;
                    end
                    state_q   <= ST_MODIFY;
                    bram_we_q <= 1'b1;
                end
                ST_MODIFY: begin
                    pending_clear_q <= 1'b0;
                    if (pending_clear_q || clear_req) begin
                        state_q <= ST_CLEAR;
                    end else begin
                        state_q    <= ST_IDLE;
                        in_ready_q <= 1'b1;
                        bram_en_q  <= 1'b0;
                        bram_we_q  <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (seq_done) begin
                        state_q    <= ST_IDLE;
                        in_ready_q <= 1'b1;
                        bram_en_q  <= 1'b0;
                        bram_we_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b1;
                    bram_en_q  <= 1'b0;
                    bram_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pixel_mask = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << off_q;

    assign in_ready   = in_ready_q;
    assign clear_busy = seq_busy;
    assign bram_en    = bram_en_q;
    assign bram_we    = bram_we_q;
    assign bram_addr  = (state_q == ST_CLEAR) ? seq_addr : addr_q;
    // Read data only exists during MODIFY, so the merge cannot be registered.
    assign bram_din   = (state_q == ST_MODIFY) ? (bram_dout | pixel_mask) : '0;
    assign dropped    = dropped_q;

`ifdef FRAMEBUFFER_PIXEL_WRITER_STATS_EN
    logic [31:0] pixel_count_q, pixel_count_d;

    always_comb begin
        pixel_count_d = pixel_count_q;
        if (clear_start) begin
            pixel_count_d = '0;
        end else if ((state_q == ST_MODIFY) && (pixel_count_q != 32'hFFFF_FFFF)) begin
            pixel_count_d = pixel_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pixel_count_q <= '0;
        end else begin
            pixel_count_q <= pixel_count_d;
        end
    end

    assign pixel_count = pixel_count_q;
`endif

endmodule
